// File: rtl/note_pkg.sv
// Shared types and constants for the multi-lane falling-note engine.
package note_pkg;

  typedef enum logic [1:0] {WAIT, FALL, HIT, MISS} lane_state_t;
  typedef enum logic [1:0] {HALTED, RUN, DONE} game_state_t;

  localparam logic [7:0] KEY_START   = 8'h2C;
  localparam logic [7:0] KEY_RESTART = 8'h01;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {13'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {5'd0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/note_lane.sv
// One falling-note lane: delay counter, y position, key edge detect and hit/miss judging.
module note_lane
  import note_pkg::*;
#(
  parameter logic [7:0]  LANE_KEY = 8'h07,
  parameter logic [11:0] DELAY    = 12'd220,
  parameter int          Y_START  = 100,
  parameter int          Y_MAX    = 400,
  parameter int          HIT_TOP  = 340,
  parameter int          NOTE_H   = 40,
  parameter int          SPEED    = 1
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        load,
  input  logic        run,
  input  logic [7:0]  keycode,
  input  logic [7:0]  keycode_second,
  output lane_state_t state,
  output logic [9:0]  y,
  output logic        visible,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic        hit_now,
  output logic        miss_now
);

  lane_state_t state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [9:0]  y_q, y_d;
  logic        press_q, press_d;
  logic        visible_q, visible_d;
  logic        hit_q, miss_q;
  logic        press_edge;
  logic [10:0] bottom;

  assign press_d    = (keycode == LANE_KEY) || (keycode_second == LANE_KEY);
  assign press_edge = press_d && !press_q;
  assign bottom     = {1'b0, y_q} + 11'(NOTE_H);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    hit_now  = 1'b0;
    miss_now = 1'b0;
    if (load) begin
      state_d = WAIT;
      cnt_d   = 12'd0;
      y_d     = 10'(Y_START);
    end else if (run) begin
      case (state_q)
        WAIT: begin
          if (cnt_q == DELAY) state_d = FALL;
          else                cnt_d   = cnt_q + 12'd1;
        end
        FALL: begin
          // Reaching the floor wins over a simultaneous in-window press.
          if (bottom >= 11'(Y_MAX)) begin
            state_d  = MISS;
            miss_now = 1'b1;
          end else if (press_edge && (bottom >= 11'(HIT_TOP))) begin
            state_d = HIT;
            hit_now = 1'b1;
          end else begin
            y_d = y_q + 10'(SPEED);
          end
        end
        default: ;
      endcase
    end
    visible_d = !((state_d == HIT) || (state_d == MISS));
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= WAIT;
      cnt_q     <= 12'd0;
      y_q       <= 10'(Y_START);
      press_q   <= 1'b0;
      visible_q <= 1'b1;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      press_q   <= press_d;
      visible_q <= visible_d;
      hit_q     <= hit_now;
      miss_q    <= miss_now;
    end
  end

  assign state      = state_q;
  assign y          = y_q;
  assign visible    = visible_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule

// File: rtl/note_lane_dropper.sv
// Multi-lane note engine: global start/restart FSM, lane array and score/combo tally for the HUD.
module note_lane_dropper
  import note_pkg::*;
#(
  parameter int                LANES       = 4,
  parameter logic [LANES*8-1:0]  LANE_KEYS   = {8'h0E, 8'h0D, 8'h09, 8'h07},
  parameter logic [LANES*12-1:0] LANE_DELAYS = {12'd340, 12'd300, 12'd260, 12'd220},
  parameter int                Y_START     = 100,
  parameter int                Y_MAX       = 400,
  parameter int                HIT_TOP     = 340,
  parameter int                NOTE_H      = 40,
  parameter int                SPEED       = 1
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic [7:0]          keycode,
  input  logic [7:0]          keycode_second,
  output logic [LANES*10-1:0] note_y,
  output logic [LANES-1:0]    note_visible,
  output logic [LANES-1:0]    hit_pulse,
  output logic [LANES-1:0]    miss_pulse,
  output logic [15:0]         score,
  output logic [7:0]          combo,
  output logic                done
);

  game_state_t game_q, game_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  combo_q, combo_d;
  logic        done_q;
  logic        start_run, restart, load, run;
  logic        all_judged, any_miss;
  logic [3:0]  n_hits;
  lane_state_t      lane_state [LANES];
  logic [LANES-1:0] hit_now, miss_now;

  assign start_run = (game_q == HALTED) && (keycode == KEY_START);
  assign restart   = (game_q == DONE) && (keycode == KEY_RESTART);
  assign load      = start_run || restart;
  assign run       = (game_q == RUN);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    note_lane #(
      .LANE_KEY (LANE_KEYS[i*8 +: 8]),
      .DELAY    (LANE_DELAYS[i*12 +: 12]),
      .Y_START  (Y_START),
      .Y_MAX    (Y_MAX),
      .HIT_TOP  (HIT_TOP),
      .NOTE_H   (NOTE_H),
      .SPEED    (SPEED)
    ) u_lane (
      .frame_clk      (frame_clk),
      .Reset          (Reset),
      .load           (load),
      .run            (run),
      .keycode        (keycode),
      .keycode_second (keycode_second),
      .state          (lane_state[i]),
      .y              (note_y[i*10 +: 10]),
      .visible        (note_visible[i]),
      .hit_pulse      (hit_pulse[i]),
      .miss_pulse     (miss_pulse[i]),
      .hit_now        (hit_now[i]),
      .miss_now       (miss_now[i])
    );
  end

  always_comb begin
    all_judged = 1'b1;
    n_hits     = 4'd0;
    for (int i = 0; i < LANES; i++) begin
      if (!((lane_state[i] == HIT) || (lane_state[i] == MISS))) all_judged = 1'b0;
      n_hits = n_hits + {3'd0, hit_now[i]};
    end
    any_miss = |miss_now;
  end

  always_comb begin
    game_d = game_q;
    case (game_q)
      HALTED:  if (start_run) game_d = RUN;
      RUN:     if (all_judged) game_d = DONE;
      DONE:    if (restart) game_d = HALTED;
      default: game_d = HALTED;
    endcase
  end

  // A miss in the same frame clears combo before that frame's hits are added.
  always_comb begin
    if (start_run) begin
      score_d = 16'd0;
      combo_d = 8'd0;
    end else begin
      score_d = sat_add16(score_q, n_hits);
      combo_d = sat_add8(any_miss ? 8'd0 : combo_q, n_hits);
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      game_q  <= HALTED;
      score_q <= 16'd0;
      combo_q <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      game_q  <= game_d;
      score_q <= score_d;
      combo_q <= combo_d;
      done_q  <= (game_d == DONE);
    end
  end

  assign score = score_q;
  assign combo = combo_q;
  assign done  = done_q;

endmodule

// File: tb/tb_note_lane_dropper.sv
// Randomised and scripted games against a closed-form timeline model of the note engine.
module tb_note_lane_dropper;

  localparam int LANES   = 4;
  localparam int Y_START = 100;
  localparam int Y_MAX   = 400;
  localparam int HIT_TOP = 340;
  localparam int NOTE_H  = 40;
  localparam int SPEED   = 1;

  logic                frame_clk = 1'b0;
  logic                Reset;
  logic [7:0]          keycode, keycode_second;
  logic [LANES*10-1:0] note_y;
  logic [LANES-1:0]    note_visible, hit_pulse, miss_pulse;
  logic [15:0]         score;
  logic [7:0]          combo;
  logic                done;

  note_lane_dropper #(
    .LANES       (LANES),
    .LANE_KEYS   ({8'h0E, 8'h0D, 8'h09, 8'h07}),
    .LANE_DELAYS ({12'd340, 12'd300, 12'd260, 12'd220}),
    .Y_START     (Y_START),
    .Y_MAX       (Y_MAX),
    .HIT_TOP     (HIT_TOP),
    .NOTE_H      (NOTE_H),
    .SPEED       (SPEED)
  ) dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .keycode        (keycode),
    .keycode_second (keycode_second),
    .note_y         (note_y),
    .note_visible   (note_visible),
    .hit_pulse      (hit_pulse),
    .miss_pulse     (miss_pulse),
    .score          (score),
    .combo          (combo),
    .done           (done)
  );

  always #5 frame_clk = ~frame_clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: game 0=halted 1=run 2=done; lane position is a function of frames since start.
  int  key_of [LANES] = '{8'h07, 8'h09, 8'h0D, 8'h0E};
  int  del_of [LANES] = '{220, 260, 300, 340};
  int  g, n_start, e, games;
  bit  judged [LANES];
  int  jy [LANES];
  bit  mpq [LANES];
  bit  mhit [LANES];
  bit  mmiss [LANES];
  int  mscore, mcombo;

  task automatic model_reset();
    g = 0;
    mscore = 0;
    mcombo = 0;
    for (int i = 0; i < LANES; i++) begin
      judged[i] = 0; mpq[i] = 0; mhit[i] = 0; mmiss[i] = 0; jy[i] = Y_START;
    end
  endtask

  function automatic int exp_y(input int i);
    int k;
    if (judged[i]) return jy[i];
    if (g != 1) return Y_START;
    k = e - n_start - del_of[i] - 1;
    return Y_START + SPEED * ((k > 0) ? k : 0);
  endfunction

  task automatic model_step(input int kc, input int kc2);
    bit edge_i [LANES];
    bit all_prev, miss;
    int hits, y, k;
    e++;
    for (int i = 0; i < LANES; i++) begin
      bit p;
      p = (kc == key_of[i]) || (kc2 == key_of[i]);
      edge_i[i] = p && !mpq[i];
      mpq[i] = p;
      mhit[i] = 0;
      mmiss[i] = 0;
    end
    if (g == 1) begin
      all_prev = 1;
      hits = 0;
      miss = 0;
      for (int i = 0; i < LANES; i++) if (!judged[i]) all_prev = 0;
      for (int i = 0; i < LANES; i++) begin
        if (!judged[i] && (e >= n_start + del_of[i] + 2)) begin
          k = e - n_start - del_of[i] - 2;
          y = Y_START + SPEED * k;
          if (y + NOTE_H >= Y_MAX) begin
            judged[i] = 1; jy[i] = y; mmiss[i] = 1; miss = 1;
          end else if (edge_i[i] && (y + NOTE_H >= HIT_TOP)) begin
            judged[i] = 1; jy[i] = y; mhit[i] = 1; hits++;
          end
        end
      end
      if (miss) mcombo = 0;
      mcombo = (mcombo + hits > 255) ? 255 : mcombo + hits;
      mscore = (mscore + hits > 65535) ? 65535 : mscore + hits;
      if (all_prev) g = 2;
    end else if (g == 0 && kc == 8'h2C) begin
      g = 1;
      n_start = e;
      games++;
      mscore = 0;
      mcombo = 0;
      for (int i = 0; i < LANES; i++) begin judged[i] = 0; jy[i] = Y_START; end
    end else if (g == 2 && kc == 8'h01) begin
      g = 0;
      for (int i = 0; i < LANES; i++) begin judged[i] = 0; jy[i] = Y_START; end
    end
  endtask

  task automatic check_all(input string where);
    logic [LANES*10-1:0] ey;
    logic [LANES-1:0]    ev, eh, em;
    for (int i = 0; i < LANES; i++) begin
      ey[i*10 +: 10] = 10'(exp_y(i));
      ev[i] = !judged[i];
      eh[i] = mhit[i];
      em[i] = mmiss[i];
    end
    check({where, ".note_y"},       64'(note_y),       64'(ey));
    check({where, ".note_visible"}, 64'(note_visible), 64'(ev));
    check({where, ".hit_pulse"},    64'(hit_pulse),    64'(eh));
    check({where, ".miss_pulse"},   64'(miss_pulse),   64'(em));
    check({where, ".score"},        64'(score),        64'(mscore));
    check({where, ".combo"},        64'(combo),        64'(mcombo));
    check({where, ".done"},         64'(done),         64'(g == 2));
  endtask

  function automatic int rand_key(input int prev);
    int r;
    if ($urandom_range(0, 99) < 70) return prev;
    r = $urandom_range(0, 99);
    if (r < 50) return 0;
    if (r < 90) return key_of[$urandom_range(0, LANES - 1)];
    return $urandom_range(0, 255);
  endfunction

  initial begin
    int kc, kc2, r;
    bit did_reset;
    e = 0;
    games = 0;
    did_reset = 0;
    kc = 0;
    kc2 = 0;
    Reset = 1'b1;
    keycode = 8'h00;
    keycode_second = 8'h00;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b0;

    for (int frame = 0; frame < 9000; frame++) begin
      @(negedge frame_clk);
      r = $urandom_range(0, 99);
      if (g == 0) begin
        kc  = (r < 20) ? 8'h2C : 0;
        kc2 = 0;
      end else if (g == 2) begin
        kc  = (r < 20) ? 8'h01 : (r < 40) ? 8'h2C : 0;
        kc2 = 0;
      end else if (games == 1) begin
        kc = 0;
        kc2 = 0;
      end else if (games == 2) begin
        kc = 0;
        kc2 = 0;
        if (!judged[1] && exp_y(1) == 300) begin
          kc = 8'h07; kc2 = 8'h09;
        end else if (!judged[2] && exp_y(2) >= 290) begin
          kc2 = 8'h0D;
        end
        if (!judged[3] && exp_y(3) == 359) kc = 8'h0E;
      end else begin
        kc  = rand_key(kc);
        kc2 = rand_key(kc2);
      end
      keycode = 8'(kc);
      keycode_second = 8'(kc2);

      if (!did_reset && games >= 3 && g == 1 && !judged[0] && exp_y(0) == 250) begin
        Reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        #1;
        Reset = 1'b0;
        did_reset = 1;
        kc = 0;
        kc2 = 0;
        keycode = 8'h00;
        keycode_second = 8'h00;
      end

      @(posedge frame_clk);
      model_step(kc, kc2);
      #1;
      check_all("frame");
      if (games >= 8 && g == 0) break;
    end
    check(64'(games >= 4) ? "games_played" : "games_played", 64'(games >= 4), 64'd1);
    check("async_reset_hit", 64'(did_reset), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
